ws281x_rx: RTL and testbench

WS281x single-wire receiver/decoder that turns a serial LED bitstream back into 24-bit GRB words. It samples an asynchronous input, measures each high pulse against a programmable threshold to decide 0/1, assembles words MSB-first, detects the reset (latch) gap, and presents each word through a single-entry holding register with a read-strobe handshake. Its register front-end is a peer of the existing ws281x register block, so a chip can loop transmit ports back for self-test or decode an upstream LED chain.

---
 rtl/ws281x_rx.sv | 146 ++++++++++++++
 tb/tb_ws281x_rx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ws281x_rx.sv
// ws281x_rx: WS281x single-wire receiver; decodes high-pulse widths into 24-bit
// GRB words with reset-gap detection and a single-entry read-strobe holding register.
module ws281x_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        mclk,
  input  logic        h_reset_n,
  input  logic        cfg_enb,
  input  logic [9:0]  cfg_bit_thresh,
  input  logic [9:0]  cfg_max_high,
  input  logic [15:0] cfg_reset_period,
  input  logic        ws_din,
  input  logic        rx_rd,
  input  logic        sts_clr,
  output logic [23:0] rx_data,
  output logic        rx_dval,
  output logic        rx_frame_end,
  output logic        rx_ovf,
  output logic        rx_err
);
  typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic        din_d_q;
  logic [15:0] low_cnt_q, low_cnt_d, low_inc;
  logic [9:0]  high_cnt_q, high_cnt_d, high_inc;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] shift_q, shift_d, data_q, data_d;
  logic        frame_q, frame_d, dval_q, dval_d, fe_q, fe_d, ovf_q, ovf_d, err_q, err_d;
  logic        din_s, rise, fall, bit_v, done;
  assign din_s    = sync_q[SYNC_STAGES-1];
  assign rise     = !din_d_q & din_s;
  assign fall     = din_d_q & !din_s;
  assign bit_v    = high_cnt_q >= cfg_bit_thresh;
  assign low_inc  = (low_cnt_q == 16'hFFFF) ? low_cnt_q : low_cnt_q + 16'd1;
  assign high_inc = (high_cnt_q == 10'h3FF) ? high_cnt_q : high_cnt_q + 10'd1;
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      sync_q     <= '0;
      din_d_q    <= 1'b0;
      state_q    <= SYNC;
      low_cnt_q  <= '0;
      high_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      frame_q    <= 1'b0;
      data_q     <= '0;
      dval_q     <= 1'b0;
      fe_q       <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ws_din};
      din_d_q    <= din_s;
      state_q    <= state_d;
      low_cnt_q  <= low_cnt_d;
      high_cnt_q <= high_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      frame_q    <= frame_d;
      data_q     <= data_d;
      dval_q     <= dval_d;
      fe_q       <= fe_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    low_cnt_d  = low_cnt_q;
    high_cnt_d = high_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frame_d    = frame_q;
    data_d     = data_q;
    dval_d     = dval_q;
    fe_d       = 1'b0;
    ovf_d      = ovf_q & !sts_clr;
    err_d      = err_q & !sts_clr;
    done       = 1'b0;
    if (!cfg_enb) begin
      state_d    = SYNC;
      low_cnt_d  = '0;
      high_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = '0;
      frame_d    = 1'b0;
    end else begin
      case (state_q)
        SYNC: begin
          low_cnt_d = din_s ? '0 : low_inc;
          if (low_cnt_q == cfg_reset_period) state_d = LOW;
        end
        LOW: begin
          low_cnt_d = low_inc;
          if (rise) begin
            state_d    = HIGH;
            high_cnt_d = 10'd1;
          end
          if (low_cnt_q == cfg_reset_period) begin
            fe_d    = frame_q;
            frame_d = 1'b0;
            if (bit_cnt_q != 5'd0) begin
              err_d     = 1'b1;
              bit_cnt_d = '0;
              shift_d   = '0;
            end
          end
        end
        HIGH: begin
          high_cnt_d = high_inc;
          if (high_cnt_q > cfg_max_high) begin
            err_d     = 1'b1;
            bit_cnt_d = '0;
            low_cnt_d = '0;
            state_d   = SYNC;
          end else if (fall) begin
            shift_d   = {shift_q[22:0], bit_v};
            frame_d   = 1'b1;
            low_cnt_d = 16'd1;
            state_d   = LOW;
            done      = bit_cnt_q == 5'd23;
            bit_cnt_d = done ? 5'd0 : bit_cnt_q + 5'd1;
          end
        end
        default: state_d = SYNC;
      endcase
    end
    // A read in the completion cycle frees the slot for the new word
    if (done) begin
      if (!dval_q || rx_rd) begin
        data_d = {shift_q[22:0], bit_v};
        dval_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (rx_rd) begin
      dval_d = 1'b0;
    end
  end
  assign rx_data      = data_q;
  assign rx_dval      = dval_q;
  assign rx_frame_end = fe_q;
  assign rx_ovf       = ovf_q;
  assign rx_err       = err_q;
endmodule

// File: tb/tb_ws281x_rx.sv
// tb_ws281x_rx: directed self-checking bench for ws281x_rx.
module tb_ws281x_rx;
  logic        mclk = 0;
  logic        h_reset_n = 0;
  logic        cfg_enb = 1;
  logic [9:0]  cfg_bit_thresh = 10'd40;
  logic [9:0]  cfg_max_high = 10'd100;
  logic [15:0] cfg_reset_period = 16'd500;
  logic        ws_din = 0;
  logic        rx_rd = 0;
  logic        sts_clr = 0;
  logic [23:0] rx_data;
  logic        rx_dval, rx_frame_end, rx_ovf, rx_err;
  int n_checks = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int fe_base;
  ws281x_rx #(.SYNC_STAGES(2)) dut (
    .mclk(mclk), .h_reset_n(h_reset_n), .cfg_enb(cfg_enb),
    .cfg_bit_thresh(cfg_bit_thresh), .cfg_max_high(cfg_max_high),
    .cfg_reset_period(cfg_reset_period), .ws_din(ws_din), .rx_rd(rx_rd),
    .sts_clr(sts_clr), .rx_data(rx_data), .rx_dval(rx_dval),
    .rx_frame_end(rx_frame_end), .rx_ovf(rx_ovf), .rx_err(rx_err)
  );
  always #5 mclk = ~mclk;
  always @(negedge mclk) if (rx_frame_end) fe_cnt++;
  task automatic tick(input int n);
    repeat (n) @(negedge mclk);
  endtask
  task automatic pulse(input int hi, input int lo);
    ws_din = 1;
    tick(hi);
    ws_din = 0;
    tick(lo);
  endtask
  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) pulse(w[i] ? 60 : 20, w[i] ? 65 : 105);
  endtask
  task automatic read_word();
    rx_rd = 1;
    tick(1);
    rx_rd = 0;
  endtask
  task automatic clear_sts();
    sts_clr = 1;
    tick(1);
    sts_clr = 0;
  endtask
  task automatic test_reset();
    h_reset_n = 0;
    tick(3);
    n_checks++; if (rx_data !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000000", rx_data); end
    n_checks++; if (rx_dval !== 1'b0) begin n_fail++; $display("FAIL reset_dval: got %b want 0", rx_dval); end
    n_checks++; if (rx_frame_end !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b want 0", rx_frame_end); end
    n_checks++; if ({rx_ovf, rx_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {rx_ovf, rx_err}); end
    h_reset_n = 1;
    tick(510);
    n_checks++; if (dut.state_q !== 2'd1) begin n_fail++; $display("FAIL reset_low_state: got %0d want 1", dut.state_q); end
    n_checks++; if ({rx_dval, rx_ovf, rx_err, rx_data} !== 27'h0 || fe_cnt != 0) begin n_fail++; $display("FAIL reset_quiet: got dval=%b ovf=%b err=%b data=%h fe=%0d want all 0", rx_dval, rx_ovf, rx_err, rx_data, fe_cnt); end
  endtask
  task automatic test_single_word();
    fe_base = fe_cnt;
    send_bits(24'hA5C3F0, 24);
    tick(600);
    n_checks++; if (rx_data !== 24'hA5C3F0) begin n_fail++; $display("FAIL single_data: got %h want a5c3f0", rx_data); end
    n_checks++; if (rx_dval !== 1'b1) begin n_fail++; $display("FAIL single_dval: got %b want 1", rx_dval); end
    n_checks++; if (fe_cnt - fe_base != 1) begin n_fail++; $display("FAIL single_frame_end: got %0d pulses want 1", fe_cnt - fe_base); end
    n_checks++; if ({rx_ovf, rx_err} !== 2'b00) begin n_fail++; $display("FAIL single_flags: got %b want 00", {rx_ovf, rx_err}); end
    read_word();
    n_checks++; if (rx_dval !== 1'b0) begin n_fail++; $display("FAIL single_read: got dval=%b want 0", rx_dval); end
  endtask
  task automatic test_back_to_back();
    send_bits(24'h123456, 24);
    send_bits(24'hFEDCBA, 24);
    tick(600);
    n_checks++; if (rx_data !== 24'h123456) begin n_fail++; $display("FAIL b2b_data: got %h want 123456", rx_data); end
    n_checks++; if (rx_ovf !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf: got %b want 1", rx_ovf); end
    clear_sts();
    n_checks++; if (rx_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf_clr: got %b want 0", rx_ovf); end
    read_word();
  endtask
  task automatic test_partial_word();
    fe_base = fe_cnt;
    send_bits(24'hABC000, 12);
    tick(600);
    n_checks++; if (rx_err !== 1'b1) begin n_fail++; $display("FAIL partial_err: got %b want 1", rx_err); end
    n_checks++; if (rx_dval !== 1'b0) begin n_fail++; $display("FAIL partial_dval: got %b want 0", rx_dval); end
    n_checks++; if (fe_cnt - fe_base != 1) begin n_fail++; $display("FAIL partial_frame_end: got %0d pulses want 1", fe_cnt - fe_base); end
    clear_sts();
    send_bits(24'h00FF00, 24);
    tick(600);
    n_checks++; if (rx_data !== 24'h00FF00 || rx_dval !== 1'b1 || rx_err !== 1'b0) begin n_fail++; $display("FAIL partial_next: got data=%h dval=%b err=%b want 00ff00 1 0", rx_data, rx_dval, rx_err); end
    read_word();
  endtask
  task automatic test_long_high();
    send_bits(24'hF00000, 5);
    ws_din = 1;
    tick(150);
    n_checks++; if (rx_err !== 1'b1) begin n_fail++; $display("FAIL long_high_err: got %b want 1", rx_err); end
    n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL long_high_sync: got %0d want 0", dut.state_q); end
    ws_din = 0;
    tick(100);
    send_bits(24'hE00000, 3);
    tick(600);
    n_checks++; if (rx_dval !== 1'b0) begin n_fail++; $display("FAIL long_high_ignored: got dval=%b want 0", rx_dval); end
    clear_sts();
  endtask
  task automatic test_boundaries();
    for (int i = 0; i < 12; i++) begin
      pulse(40, 85);
      pulse(39, 85);
    end
    tick(600);
    n_checks++; if (rx_data !== 24'hAAAAAA) begin n_fail++; $display("FAIL thresh_edge: got %h want aaaaaa", rx_data); end
    send_bits(24'h5A5A5A, 23);
    ws_din = 1;
    tick(20);
    ws_din = 0;
    tick(2);
    rx_rd = 1;
    tick(1);
    rx_rd = 0;
    n_checks++; if (rx_dval !== 1'b1 || rx_data !== 24'h5A5A5A || rx_ovf !== 1'b0) begin n_fail++; $display("FAIL rd_same_cycle: got dval=%b data=%h ovf=%b want 1 5a5a5a 0", rx_dval, rx_data, rx_ovf); end
    tick(600);
    read_word();
    cfg_bit_thresh = 10'd0;
    send_bits(24'h000000, 24);
    tick(600);
    n_checks++; if (rx_data !== 24'hFFFFFF) begin n_fail++; $display("FAIL thresh_zero: got %h want ffffff", rx_data); end
    read_word();
    cfg_bit_thresh = 10'd40;
  endtask
  task automatic test_disable();
    send_bits(24'hC3C000, 10);
    cfg_enb = 0;
    tick(5);
    cfg_enb = 1;
    fe_base = fe_cnt;
    tick(600);
    n_checks++; if (fe_cnt != fe_base || rx_err !== 1'b0 || rx_dval !== 1'b0) begin n_fail++; $display("FAIL disable_discard: got fe=%0d err=%b dval=%b want fe=0 err=0 dval=0", fe_cnt - fe_base, rx_err, rx_dval); end
    send_bits(24'h0F0F0F, 24);
    tick(600);
    n_checks++; if (rx_data !== 24'h0F0F0F || rx_dval !== 1'b1 || fe_cnt - fe_base != 1) begin n_fail++; $display("FAIL disable_next: got data=%h dval=%b fe=%0d want 0f0f0f 1 1", rx_data, rx_dval, fe_cnt - fe_base); end
  endtask
  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_partial_word();
    test_long_high();
    test_boundaries();
    test_disable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
